// File: rtl/prog_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words, writes
// them into the instruction ROM and releases the core's reset once the program is in.
module prog_loader #(
   parameter int unsigned SIZE       = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic                  BYTE_VALID,
   input  logic [7:0]            BYTE_DATA,
   output logic                  BYTE_READY,
   output logic                  ROM_WE,
   output logic [ADDR_WIDTH-1:0] ROM_ADDR,
   output logic [SIZE-1:0]       ROM_WDATA,
   output logic                  CORE_RESET_N,
   output logic                  DONE,
   output logic                  ERROR,
   output logic [ADDR_WIDTH:0]   WORDS_LOADED
);

   localparam int unsigned CAP = 1 << ADDR_WIDTH;
   localparam int unsigned WW  = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR0  = 3'd1,
      S_HDR1  = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         n_q;
   logic [1:0]          byte_idx_q;
   logic [SIZE-9:0]     word_q;
   logic [ADDR_WIDTH:0] widx_q;
   logic [ADDR_WIDTH:0] widx_inc;
   logic [15:0]         n_hdr;
   logic                xfer;

   assign xfer     = BYTE_VALID & BYTE_READY;
   assign widx_inc = widx_q + WW'(1);
   assign n_hdr    = {BYTE_DATA, n_q[7:0]};

   // Next-state selection; outputs below are registered from state_d.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = S_HDR0;
         S_HDR0:  if (xfer) state_d = S_HDR1;
         S_HDR1: begin
            if (xfer) begin
               if (n_hdr == 16'd0)            state_d = S_DONE;
               else if (32'(n_hdr) > CAP)     state_d = S_ERR;
               else                           state_d = S_DATA;
            end
         end
         S_DATA:  if (xfer && (byte_idx_q == 2'd3)) state_d = S_WRITE;
         S_WRITE: state_d = (32'(widx_inc) == 32'(n_q)) ? S_DONE : S_DATA;
         S_DONE:  if (START) state_d = S_HDR0;
         S_ERR:   if (START) state_d = S_HDR0;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         n_q          <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         widx_q       <= '0;
         BYTE_READY   <= 1'b0;
         ROM_WE       <= 1'b0;
         ROM_ADDR     <= '0;
         ROM_WDATA    <= '0;
         CORE_RESET_N <= 1'b0;
         DONE         <= 1'b0;
         ERROR        <= 1'b0;
         WORDS_LOADED <= '0;
      end else begin
         state_q      <= state_d;
         BYTE_READY   <= (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
         ROM_WE       <= (state_d == S_WRITE);
         CORE_RESET_N <= (state_d == S_DONE);
         DONE         <= (state_d == S_DONE);
         ERROR        <= (state_d == S_ERR);

         case (state_q)
            S_HDR0: if (xfer) n_q[7:0] <= BYTE_DATA;
            S_HDR1: if (xfer) n_q[15:8] <= BYTE_DATA;
            S_DATA: begin
               if (xfer) begin
                  byte_idx_q <= byte_idx_q + 2'd1;
                  case (byte_idx_q)
                     2'd0: word_q[7:0]   <= BYTE_DATA;
                     2'd1: word_q[15:8]  <= BYTE_DATA;
                     2'd2: word_q[23:16] <= BYTE_DATA;
                     default: begin
                        // Top lane goes straight into the write register.
                        ROM_WDATA <= {BYTE_DATA, word_q};
                        ROM_ADDR  <= widx_q[ADDR_WIDTH-1:0];
                     end
                  endcase
               end
            end
            S_WRITE: begin
               widx_q       <= widx_inc;
               WORDS_LOADED <= widx_inc;
            end
            S_IDLE, S_DONE, S_ERR: begin
               if (START) begin
                  widx_q       <= '0;
                  WORDS_LOADED <= '0;
                  byte_idx_q   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a stream-level model predicts the ROM writes
// and the DONE/ERROR outcome for each load.
module tb_prog_loader;

   typedef logic [7:0] byte_t;
   localparam int unsigned AW  = 10;
   localparam int unsigned CAP = 1024;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          START;
   logic          BYTE_VALID;
   logic [7:0]    BYTE_DATA;
   logic          BYTE_READY;
   logic          ROM_WE;
   logic [AW-1:0] ROM_ADDR;
   logic [31:0]   ROM_WDATA;
   logic          CORE_RESET_N;
   logic          DONE;
   logic          ERROR;
   logic [AW:0]   WORDS_LOADED;

   int vectors     = 0;
   int miscompares = 0;

   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];

   prog_loader #(.SIZE(32), .ADDR_WIDTH(AW)) dut (
      .CLK(CLK), .RESET(RESET), .START(START),
      .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_READY(BYTE_READY),
      .ROM_WE(ROM_WE), .ROM_ADDR(ROM_ADDR), .ROM_WDATA(ROM_WDATA),
      .CORE_RESET_N(CORE_RESET_N), .DONE(DONE), .ERROR(ERROR),
      .WORDS_LOADED(WORDS_LOADED)
   );

   always #5 CLK = ~CLK;

   // Record every ROM write strobe seen on the port.
   always @(negedge CLK) begin
      if (ROM_WE === 1'b1) begin
         wr_addr.push_back(ROM_ADDR);
         wr_data.push_back(ROM_WDATA);
      end
   end

   task automatic send_byte(input byte_t b, input int gap_max);
      int  g;
      bit  ok;
      g  = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      ok = 1'b0;
      repeat (g) begin
         BYTE_VALID = 1'b0;
         @(negedge CLK);
      end
      BYTE_VALID = 1'b1;
      BYTE_DATA  = b;
      for (int c = 0; c < 50; c++) begin
         if (BYTE_READY === 1'b1) begin
            @(negedge CLK);
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      if (!ok) begin
         miscompares++;
         $display("FAIL byte_accept: byte %02h not accepted within 50 cycles, ready=%b required 1", b, BYTE_READY);
      end
      vectors++;
   endtask

   // Start a load, stream it, and check the outcome against the stream-level model.
   task automatic run_load(input byte_t s[$], input int gap_max);
      int unsigned n;
      int          nsend;
      int          bad;
      int          first_bad;
      logic [31:0] exp_w;
      n         = {s[1], s[0]};
      nsend     = (n > CAP) ? 2 : s.size();
      bad       = 0;
      first_bad = -1;
      wr_addr.delete();
      wr_data.delete();

      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      vectors++;
      if (BYTE_READY !== 1'b1 || DONE !== 1'b0 || ERROR !== 1'b0 || CORE_RESET_N !== 1'b0) begin
         miscompares++;
         $display("FAIL start: ready=%b done=%b err=%b crn=%b, required 1 0 0 0",
                  BYTE_READY, DONE, ERROR, CORE_RESET_N);
      end

      for (int i = 0; i < nsend; i++) send_byte(s[i], gap_max);
      BYTE_VALID = 1'b0;

      vectors++;
      if (n > CAP) begin
         if (ERROR !== 1'b1 || BYTE_READY !== 1'b0 || CORE_RESET_N !== 1'b0 || DONE !== 1'b0) begin
            miscompares++;
            $display("FAIL error_end: err=%b ready=%b crn=%b done=%b, required 1 0 0 0",
                     ERROR, BYTE_READY, CORE_RESET_N, DONE);
         end
      end else if (n == 0) begin
         if (DONE !== 1'b1 || CORE_RESET_N !== 1'b1 || WORDS_LOADED !== '0) begin
            miscompares++;
            $display("FAIL empty_done: done=%b crn=%b words=%0d, required 1 1 0",
                     DONE, CORE_RESET_N, WORDS_LOADED);
         end
      end else begin
         if (ROM_WE !== 1'b1 || ROM_ADDR !== AW'(n - 1) || DONE !== 1'b0) begin
            miscompares++;
            $display("FAIL last_write: we=%b addr=%0d done=%b, required 1 %0d 0",
                     ROM_WE, ROM_ADDR, DONE, n - 1);
         end
         @(negedge CLK);
         vectors++;
         if (DONE !== 1'b1 || CORE_RESET_N !== 1'b1 || ROM_WE !== 1'b0 || WORDS_LOADED !== (AW+1)'(n)) begin
            miscompares++;
            $display("FAIL done: done=%b crn=%b we=%b words=%0d, required 1 1 0 %0d",
                     DONE, CORE_RESET_N, ROM_WE, WORDS_LOADED, n);
         end
      end

      for (int i = 0; i < int'((n > CAP) ? 0 : n); i++) begin
         exp_w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
         if (i >= wr_addr.size() || wr_addr[i] !== AW'(i) || wr_data[i] !== exp_w) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      vectors++;
      if (bad != 0 || wr_addr.size() != ((n > CAP) ? 0 : n)) begin
         miscompares++;
         $display("FAIL write_log: got %0d writes with %0d wrong (first at %0d), required %0d exact writes",
                  wr_addr.size(), bad, first_bad, (n > CAP) ? 0 : n);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; BYTE_VALID = 1'b0; BYTE_DATA = 8'h00;
      @(negedge CLK);
      @(negedge CLK);
      vectors++;
      if (BYTE_READY !== 1'b0 || ROM_WE !== 1'b0 || ROM_ADDR !== '0 || ROM_WDATA !== '0) begin
         miscompares++;
         $display("FAIL reset_rom: ready=%b we=%b addr=%0d wdata=%h, required all zero",
                  BYTE_READY, ROM_WE, ROM_ADDR, ROM_WDATA);
      end
      vectors++;
      if (CORE_RESET_N !== 1'b0 || DONE !== 1'b0 || ERROR !== 1'b0 || WORDS_LOADED !== '0) begin
         miscompares++;
         $display("FAIL reset_status: crn=%b done=%b err=%b words=%0d, required all zero",
                  CORE_RESET_N, DONE, ERROR, WORDS_LOADED);
      end
      RESET = 1'b0;
      repeat (2) @(negedge CLK);
      vectors++;
      if (BYTE_READY !== 1'b0 || CORE_RESET_N !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_hold: ready=%b crn=%b, required 0 0", BYTE_READY, CORE_RESET_N);
      end
   endtask

   task automatic test_basic();
      byte_t s[$];
      s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      run_load(s, 0);
   endtask

   task automatic test_empty();
      byte_t s[$];
      s = '{8'h00, 8'h00};
      run_load(s, 0);
   endtask

   task automatic test_capacity();
      byte_t s[$];
      s = '{8'h01, 8'h04};
      run_load(s, 0);
      s = '{8'h00, 8'h04};
      for (int i = 0; i < 4 * int'(CAP); i++) s.push_back(8'($urandom));
      run_load(s, 0);
   endtask

   task automatic test_gaps();
      byte_t       s[$];
      logic [31:0] ref_data[$];
      int unsigned n;
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(24, 1);
         s.delete();
         s.push_back(8'(n));
         s.push_back(8'(n >> 8));
         for (int i = 0; i < 4 * int'(n); i++) s.push_back(8'($urandom));
         run_load(s, 0);
         ref_data = wr_data;
         run_load(s, 3);
         vectors++;
         if (wr_data != ref_data) begin
            miscompares++;
            $display("FAIL gap_vs_nogap: %0d words with gaps differ from %0d gap-free words",
                     wr_data.size(), ref_data.size());
         end
      end
   endtask

   task automatic test_mid_reset();
      byte_t s[$];
      wr_addr.delete();
      wr_data.delete();
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
      for (int i = 0; i < 4; i++) send_byte(s[i], 0);
      BYTE_VALID = 1'b0;
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      vectors++;
      if (wr_addr.size() != 0 || BYTE_READY !== 1'b0 || DONE !== 1'b0 || WORDS_LOADED !== '0 || CORE_RESET_N !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: writes=%0d ready=%b done=%b words=%0d crn=%b, required 0 0 0 0 0",
                  wr_addr.size(), BYTE_READY, DONE, WORDS_LOADED, CORE_RESET_N);
      end
      s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_load(s, 0);
      vectors++;
      if (wr_data.size() != 1 || wr_data[0] !== 32'hDDCCBBAA) begin
         miscompares++;
         $display("FAIL reload_word: %0d writes, first %h, required 1 write of ddccbbaa",
                  wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0);
      end
   endtask

   task automatic test_done_restart();
      byte_t s[$];
      s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_load(s, 0);
      vectors++;
      if (wr_data.size() != 1 || wr_data[0] !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL restart_word: %0d writes, first %h, required 1 write of deadbeef",
                  wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_capacity();
      test_gaps();
      test_mid_reset();
      test_done_restart();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time instruction loader placed directly upstream of the single-cycle RISC-V core. It receives a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. Those words are written into the instruction ROM through its write port, at word addresses matching the core's `ADDR_ROM` indexing. The core is held in reset through `CORE_RESET_N` until the whole program is written.

## Interface
- `SIZE`, 32, instruction word width; must be 32 (4 bytes/word).
- `ADDR_WIDTH`, 10, ROM word-address width; capacity 2^ADDR_WIDTH words.

- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: reset is synchronous and active-high.
- `START` in 1: begin a load; sampled only in IDLE, DONE, ERR.
- `BYTE_VALID` in 1: `BYTE_DATA` is valid.
- `BYTE_DATA` in 8: stream byte.
- `BYTE_READY` out 1: loader accepts a byte this cycle.
- `ROM_WE` out 1: ROM write strobe, one cycle per word.
- `ROM_ADDR` out ADDR_WIDTH: ROM word address.
- `ROM_WDATA` out SIZE: ROM write data.
- `CORE_RESET_N` out 1: drives the core's `RESET_N`; low holds the core in reset.
- `DONE` out 1: program fully loaded.
- `ERROR` out 1: header word count exceeds capacity.
- `WORDS_LOADED` out ADDR_WIDTH+1: count of words written in the current load.

## Operation
- Handshake: a byte transfers on a rising edge where `BYTE_VALID & BYTE_READY`. `BYTE_READY` is a registered function of state: 1 in HDR0, HDR1 and DATA; 0 elsewhere.
- Stream format: 2 header bytes carrying word count N, 16-bit little-endian. Then 4·N data bytes, each word little-endian (first byte → bits [7:0]).
- States:
  - IDLE: `START` → HDR0.
  - HDR0: on transfer, N[7:0] ← byte → HDR1.
  - HDR1: on transfer, N[15:8] ← byte. N==0 → DONE; N > 2^ADDR_WIDTH → ERR; else → DATA. N == 2^ADDR_WIDTH is legal.
  - DATA: each transfer shifts the byte into lane `byte_idx` (2-bit counter, wraps 3→0). The transfer with `byte_idx`==3 → WRITE.
  - WRITE: `ROM_WE`=1 for exactly this cycle, with `ROM_ADDR`=word index and `ROM_WDATA`=assembled word. At the edge, word index and `WORDS_LOADED` increment. `WORDS_LOADED`==N after increment → DONE, else → DATA.
  - DONE: `DONE`=1, `CORE_RESET_N`=1. `START` → HDR0, clearing `DONE`, `WORDS_LOADED`, word index, and `byte_idx`.
  - ERR: `ERROR`=1, `CORE_RESET_N`=0. `START` → HDR0, clearing `ERROR`.
- `START` in HDR0/HDR1/DATA/WRITE is ignored.
- Word index is ADDR_WIDTH+1 bits internally. `ROM_ADDR` is its low ADDR_WIDTH bits; the top bit is never set during a write, because N ≤ 2^ADDR_WIDTH.
- `CORE_RESET_N` is 0 in every state except DONE.
- Reset mid-operation: return to IDLE, discard the partial word, suppress `ROM_WE`; words already written remain in the ROM.

## Timing
- Reset values:
  - state IDLE
  - `BYTE_READY`=0, `ROM_WE`=0, `ROM_ADDR`=0, `ROM_WDATA`=0
  - `CORE_RESET_N`=0, `DONE`=0, `ERROR`=0, `WORDS_LOADED`=0
  - `byte_idx`=0, N=0
- All outputs are registered; none combinationally depends on inputs.
- `START` sampled high in IDLE at edge k → `BYTE_READY`=1 from cycle k+1.
- 4th data byte accepted at edge k → `ROM_WE`=1 in cycle k+1; ROM captures at edge k+2. `BYTE_READY`=0 in cycle k+1, so `BYTE_VALID` held through WRITE is not consumed.
- Throughput: at most one word per 5 cycles (4 transfers + 1 WRITE).
- Last WRITE in cycle k+1 → `DONE`=1 and `CORE_RESET_N`=1 from cycle k+2.
- N==0: HDR1 transfer at edge k → `DONE`=1 and `CORE_RESET_N`=1 from cycle k+1.
- `START` accepted in DONE at edge k → `CORE_RESET_N`=0 and `DONE`=0 from cycle k+1.
- Idle gaps (`BYTE_VALID`=0) in any accepting state hold all state and counters.

## Test plan
- Reset, `START`, stream 02 00 13 05 10 00 93 05 20 00 → `ROM_WE` pulses with (0, 0x00100513) then (1, 0x00200593); `DONE`=1, `CORE_RESET_N`=1 the cycle after the 2nd write; `WORDS_LOADED`=2.
- Header 00 00 → no `ROM_WE`; `DONE`=1, `CORE_RESET_N`=1 one cycle after the 2nd header byte.
- Header 01 04 (N=1025) → `ERROR`=1, `BYTE_READY`=0, `CORE_RESET_N`=0. Then `START` with header 00 04 → accepted, 1024 words written to addresses 0..1023, `DONE`=1.
- Random 0–3 cycle `BYTE_VALID` gaps, with `BYTE_VALID` held high across WRITE cycles → same ROM contents as the gap-free run; no byte lost or duplicated.
- `RESET` after header 01 00 plus 2 data bytes → IDLE, no `ROM_WE`. New load 01 00 AA BB CC DD → single write (0, 0xDDCCBBAA).
- In DONE, `START` → `CORE_RESET_N`=0 next cycle. Reload 01 00 EF BE AD DE → write (0, 0xDEADBEEF), `DONE` re-asserted.
